conv2_scheduler: RTL and testbench
==================================

Name: conv2_scheduler

Overview:
- Sequencer for the stage-2 36-tap convolution datapath (6x6 window, 8-bit image x 8-bit pattern, 22-bit sum).
- Walks every 6x6 window position of a multi-channel input feature map and, per channel, clears the datapath, then streams 36 image/pattern address pairs.
- Waits out the datapath pipeline latency, then accumulates the per-channel sums plus a bias.
- Emits one result per window on a valid/ready handshake.

Parameters:
- IN_W, 9, input map width in pixels
- IN_H, 9, input map height in pixels
- K, 6, window side; K*K = 36 must match the datapath
- NUM_CH, 6, input channels accumulated per output
- PIPE_LAT, 7, cycles from the last dp_enable-high edge to valid dp_sum
- IMG_AW, 10, image address width
- PAT_AW, 8, pattern address width
- ACC_W, 26, accumulator/output width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to process the whole map
- bias  in  16  unsigned bias, sampled at start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last window is handed off
- img_rd  out  1  image memory read strobe (1-cycle read latency)
- img_addr  out  IMG_AW  ch*IN_W*IN_H + (row+r)*IN_W + (col+c)
- pat_rd  out  1  pattern memory read strobe, equal to img_rd
- pat_addr  out  PAT_AW  ch*K*K + k
- dp_clear  out  1  active-high clear to the datapath
- dp_enable  out  1  datapath load enable; img_rd delayed one cycle
- dp_sum  in  22  datapath result
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_data  out  ACC_W  bias + sum over channels of dp_sum
- out_row, out_col  out  4 each  window origin of out_data

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0, except dp_clear = 1 so the datapath is held clear.
  - State IDLE; all counters and the accumulator cleared.
  - Reset mid-operation abandons the map; no partial result is emitted.
- States:
  - IDLE: start=1 latches bias into acc, sets row=col=ch=0, busy=1, goes to CLEAR. start is ignored in all other states.
  - CLEAR: dp_clear=1 for exactly one cycle, k=0, then STREAM.
  - STREAM: img_rd=pat_rd=1 for exactly 36 consecutive cycles, k=0..35, with r=k/K and c=k%K from nested counters (no divider). Then DRAIN.
  - DRAIN: dp_enable trails the reads by one cycle (36 cycles high). The counter runs PIPE_LAT cycles after the final dp_enable-high edge, then goes to ACCUM.
  - ACCUM: acc <= acc + zero-extended dp_sum, one cycle. If ch<NUM_CH-1: ch++, go to CLEAR. Else go to OUTPUT.
  - OUTPUT:
    - out_valid=1; out_data, out_row and out_col are stable while valid and ready are not both high.
    - On valid&&ready: if the window is the last one (row=IN_H-K, col=IN_W-K), go to FINISH. Otherwise col++ (wrapping to 0 with row++), ch=0, acc=bias, go to CLEAR.
    - out_ready is ignored outside OUTPUT.
  - FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Per-channel cycle cost: 1 + 36 + 1 + PIPE_LAT + 1 = 46 at defaults. Per window: 276 + handshake cycles.
- Defaults produce 16 windows, row-major.
- Width rule: the worst case 6*36*255*255 + 65535 = 14,110,935 fits ACC_W=26 with no overflow. No saturation logic is required.
- Only dp_clear resets the datapath's internal counter. Every channel pass begins with CLEAR.

Decomposition:
- Shared package conv2_pkg holds:
  - the state enum;
  - constants K, K*K, PIPE_LAT and the dp_sum width of 22.
- One natural sub-module: conv2_win_addr_gen. It holds the row/col/ch/r/c counters and the address arithmetic, with inputs step_k, step_ch and step_win, and outputs last_k, last_ch and last_win.

Test Plan:
- All image=1, all pattern=1, bias=0, datapath attached, out_ready=1 -> 16 outputs each 216. The rows/cols sequence runs (0,0),(0,1)..(3,3). done pulses once, 1 cycle after the 16th handshake.
- All image=255, all pattern=255, bias=65535 -> every out_data = 14,110,935.
- Address check, IN_W=9: window (row 1, col 2), ch=2, k=7 -> img_addr = 162 + 2*9 + 3 = 183 and pat_addr = 79. dp_enable is high exactly 36 cycles per pass, 1 cycle after img_rd.
- Backpressure: out_ready low for 10 cycles in OUTPUT -> out_valid held, data stable, no img_rd. The next CLEAR starts 1 cycle after ready rises.
- start pulsed while busy -> ignored; output count is still 16.
- rst driven low during STREAM of window 5 -> all outputs 0 and dp_clear=1 immediately. A new start after release restarts at window (0,0) with correct sums.

Source files
------------

// File: rtl/conv2_pkg.sv
// Shared types and constants for the stage-2 convolution scheduler.
package conv2_pkg;

   localparam int unsigned CONV_K        = 6;
   localparam int unsigned CONV_TAPS     = CONV_K * CONV_K;
   localparam int unsigned CONV_PIPE_LAT = 7;
   localparam int unsigned DP_SUM_W      = 22;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_STREAM,
      ST_DRAIN,
      ST_ACCUM,
      ST_OUTPUT,
      ST_FINISH
   } state_t;

endpackage

// File: rtl/conv2_win_addr_gen.sv
// Window/channel/tap counters and image/pattern address arithmetic.
module conv2_win_addr_gen
   import conv2_pkg::*;
#(
   parameter int unsigned IN_W   = 9,
   parameter int unsigned IN_H   = 9,
   parameter int unsigned K      = CONV_K,
   parameter int unsigned NUM_CH = 6,
   parameter int unsigned IMG_AW = 10,
   parameter int unsigned PAT_AW = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              init,
   input  logic              step_k,
   input  logic              step_ch,
   input  logic              step_win,
   output logic [IMG_AW-1:0] img_addr,
   output logic [PAT_AW-1:0] pat_addr,
   output logic [3:0]        row,
   output logic [3:0]        col,
   output logic              last_k,
   output logic              last_ch,
   output logic              last_win
);

   localparam int unsigned RW  = $clog2(K + 1);
   localparam int unsigned KW  = $clog2(K * K + 1);
   localparam int unsigned CHW = $clog2(NUM_CH + 1);

   logic [RW-1:0]  r, c;
   logic [KW-1:0]  k;
   logic [CHW-1:0] ch;

   assign last_k   = (r == RW'(K - 1)) && (c == RW'(K - 1));
   assign last_ch  = (ch == CHW'(NUM_CH - 1));
   assign last_win = (row == 4'(IN_H - K)) && (col == 4'(IN_W - K));

   assign img_addr = IMG_AW'(ch) * IMG_AW'(IN_W * IN_H)
                   + (IMG_AW'(row) + IMG_AW'(r)) * IMG_AW'(IN_W)
                   + IMG_AW'(col) + IMG_AW'(c);
   assign pat_addr = PAT_AW'(ch) * PAT_AW'(K * K) + PAT_AW'(k);

   // Tap counter wraps to 0 after the last tap, so each pass starts at k=0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r   <= '0;
         c   <= '0;
         k   <= '0;
         ch  <= '0;
         row <= '0;
         col <= '0;
      end else if (init) begin
         r   <= '0;
         c   <= '0;
         k   <= '0;
         ch  <= '0;
         row <= '0;
         col <= '0;
      end else begin
         if (step_k) begin
            k <= last_k ? '0 : k + 1'b1;
            if (c == RW'(K - 1)) begin
               c <= '0;
               r <= (r == RW'(K - 1)) ? '0 : r + 1'b1;
            end else begin
               c <= c + 1'b1;
            end
         end
         if (step_ch) ch <= ch + 1'b1;
         if (step_win) begin
            ch <= '0;
            if (col == 4'(IN_W - K)) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/conv2_scheduler.sv
// Sequencer for the 36-tap convolution datapath: walks windows and channels,
// streams address pairs, waits out the pipeline and accumulates sums + bias.
module conv2_scheduler
   import conv2_pkg::*;
#(
   parameter int unsigned IN_W     = 9,
   parameter int unsigned IN_H     = 9,
   parameter int unsigned K        = CONV_K,
   parameter int unsigned NUM_CH   = 6,
   parameter int unsigned PIPE_LAT = CONV_PIPE_LAT,
   parameter int unsigned IMG_AW   = 10,
   parameter int unsigned PAT_AW   = 8,
   parameter int unsigned ACC_W    = 26
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [15:0]         bias,
   output logic                busy,
   output logic                done,
   output logic                img_rd,
   output logic [IMG_AW-1:0]   img_addr,
   output logic                pat_rd,
   output logic [PAT_AW-1:0]   pat_addr,
   output logic                dp_clear,
   output logic                dp_enable,
   input  logic [DP_SUM_W-1:0] dp_sum,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ACC_W-1:0]    out_data,
   output logic [3:0]          out_row,
   output logic [3:0]          out_col
);

   localparam int unsigned DRW = $clog2(PIPE_LAT + 1);

   state_t           state, nextState;
   logic [ACC_W-1:0] acc, biasReg;
   logic [DRW-1:0]   drainCnt;
   logic             enReg;
   logic             init, stepK, stepCh, stepWin;
   logic             lastK, lastCh, lastWin;

   conv2_win_addr_gen #(
      .IN_W   (IN_W),
      .IN_H   (IN_H),
      .K      (K),
      .NUM_CH (NUM_CH),
      .IMG_AW (IMG_AW),
      .PAT_AW (PAT_AW)
   ) uAddrGen (
      .clk      (clk),
      .rst      (rst),
      .init     (init),
      .step_k   (stepK),
      .step_ch  (stepCh),
      .step_win (stepWin),
      .img_addr (img_addr),
      .pat_addr (pat_addr),
      .row      (out_row),
      .col      (out_col),
      .last_k   (lastK),
      .last_ch  (lastCh),
      .last_win (lastWin)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= nextState;
   end

   // Next-state logic and counter step strobes
   always_comb begin
      nextState = state;
      init      = 1'b0;
      stepK     = 1'b0;
      stepCh    = 1'b0;
      stepWin   = 1'b0;
      case (state)
         ST_IDLE:   if (start) begin
                       init      = 1'b1;
                       nextState = ST_CLEAR;
                    end
         ST_CLEAR:  nextState = ST_STREAM;
         ST_STREAM: begin
                       stepK = 1'b1;
                       if (lastK) nextState = ST_DRAIN;
                    end
         ST_DRAIN:  if (drainCnt == DRW'(PIPE_LAT)) nextState = ST_ACCUM;
         ST_ACCUM:  if (lastCh) nextState = ST_OUTPUT;
                    else begin
                       stepCh    = 1'b1;
                       nextState = ST_CLEAR;
                    end
         ST_OUTPUT: if (out_ready) begin
                       if (lastWin) nextState = ST_FINISH;
                       else begin
                          stepWin   = 1'b1;
                          nextState = ST_CLEAR;
                       end
                    end
         ST_FINISH: nextState = ST_IDLE;
         default:   nextState = ST_IDLE;
      endcase
   end

   // Accumulator, latched bias, drain counter and read-delayed load enable
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc      <= '0;
         biasReg  <= '0;
         drainCnt <= '0;
         enReg    <= 1'b0;
      end else begin
         enReg    <= (state == ST_STREAM);
         drainCnt <= (state == ST_DRAIN) ? drainCnt + 1'b1 : '0;
         if (init) begin
            biasReg <= ACC_W'(bias);
            acc     <= ACC_W'(bias);
         end
         if (state == ST_ACCUM) acc <= acc + ACC_W'(dp_sum);
         if (stepWin) acc <= biasReg;
      end
   end

   // dp_clear also follows reset so the datapath is held clear while rst is low
   assign dp_clear  = (state == ST_CLEAR) || !rst;
   assign busy      = (state != ST_IDLE) && (state != ST_FINISH);
   assign done      = (state == ST_FINISH);
   assign img_rd    = (state == ST_STREAM);
   assign pat_rd    = (state == ST_STREAM);
   assign dp_enable = enReg;
   assign out_valid = (state == ST_OUTPUT);
   assign out_data  = acc;

endmodule

// File: tb/tb_conv2_scheduler.sv
// Self-checking bench for conv2_scheduler with an attached datapath/memory model.
module tb_conv2_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] bias;
   logic        busy, done, img_rd, pat_rd, dp_clear, dp_enable, out_valid, out_ready;
   logic [9:0]  img_addr;
   logic [7:0]  pat_addr;
   logic [21:0] dp_sum;
   logic [25:0] out_data;
   logic [3:0]  out_row, out_col;

   always #5 clk = ~clk;

   conv2_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bias      (bias),
      .busy      (busy),
      .done      (done),
      .img_rd    (img_rd),
      .img_addr  (img_addr),
      .pat_rd    (pat_rd),
      .pat_addr  (pat_addr),
      .dp_clear  (dp_clear),
      .dp_enable (dp_enable),
      .dp_sum    (dp_sum),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col)
   );

   // Memories (1-cycle read) and a 36-tap MAC with 7-cycle result latency
   logic [7:0]  imgMem [1024];
   logic [7:0]  patMem [256];
   logic [7:0]  imgQ, patQ;
   logic [21:0] dpAcc;
   logic [21:0] pipe [7];

   always @(posedge clk) begin
      if (img_rd) begin
         imgQ <= imgMem[img_addr];
         patQ <= patMem[pat_addr];
      end
      if (dp_clear)       dpAcc <= '0;
      else if (dp_enable) dpAcc <= dpAcc + 22'(imgQ) * 22'(patQ);
      pipe[0] <= dpAcc;
      for (int i = 1; i < 7; i++) pipe[i] <= pipe[i-1];
   end
   assign dp_sum = pipe[6];

   // Monitor: address sequence, enable timing, event totals
   int winIdx = 0, clrCnt = 0, chIdx = 0, kIdx = 0;
   int addrErrs = 0, enErrs = 0;
   int rdTot = 0, enTot = 0, clrTot = 0, doneTot = 0;
   int spotImg = 0, spotPat = 0;
   logic prevRd = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         prevRd = 1'b0;
         winIdx = 0;
         clrCnt = 0;
         kIdx   = 0;
         chIdx  = 0;
      end else begin
         if (dp_enable != prevRd) enErrs++;
         if (pat_rd != img_rd) addrErrs++;
         if (dp_enable) enTot++;
         if (!busy) begin
            winIdx = 0;
            clrCnt = 0;
         end
         if (dp_clear) begin
            chIdx = clrCnt;
            clrCnt++;
            kIdx = 0;
            clrTot++;
         end
         if (img_rd) begin
            if (int'(img_addr) != chIdx*81 + (winIdx/4 + kIdx/6)*9 + winIdx%4 + kIdx%6) addrErrs++;
            if (int'(pat_addr) != chIdx*36 + kIdx) addrErrs++;
            if (winIdx == 6 && chIdx == 2 && kIdx == 7) begin
               spotImg = int'(img_addr);
               spotPat = int'(pat_addr);
            end
            rdTot++;
            kIdx++;
         end
         if (out_valid && out_ready) begin
            winIdx++;
            clrCnt = 0;
         end
         if (done) doneTot++;
         prevRd = img_rd;
      end
   end

   typedef struct {
      logic [7:0]  imgVal;
      logic [7:0]  patVal;
      logic [15:0] biasVal;
      int unsigned expData;
      bit          useRef;
   } vec_t;

   vec_t tbl [5];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   function automatic int unsigned refWin(input int row, input int col, input int unsigned b);
      int unsigned s = b;
      for (int ch = 0; ch < 6; ch++)
         for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
               s += int'(imgMem[ch*81 + (row+r)*9 + col + c]) * int'(patMem[ch*36 + r*6 + c]);
      return s;
   endfunction

   task automatic loadMem(input int sc);
      for (int i = 0; i < 1024; i++) imgMem[i] = tbl[sc].useRef ? 8'((i*37 + 11) % 256) : tbl[sc].imgVal;
      for (int i = 0; i < 256; i++)  patMem[i] = tbl[sc].useRef ? 8'((i*13 + 5) % 256) : tbl[sc].patVal;
      bias = tbl[sc].biasVal;
   endtask

   task automatic pulseStart();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic rstChecks();
      chk("rst_ctrl", 32'({busy, done, img_rd, pat_rd, dp_enable, out_valid}), 0);
      chk("rst_dp_clear", 32'(dp_clear), 1);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_pos", 32'({out_row, out_col}), 0);
      chk("rst_addr", 32'({img_addr, pat_addr}), 0);
   endtask

   task automatic runMap(input int sc, input int bpWin, input bit spurious);
      int rd0, en0, clr0, dn0, cyc;
      int unsigned expD;
      logic [25:0] held;
      bit holdBad;
      loadMem(sc);
      out_ready = 1'b1;
      rd0 = rdTot; en0 = enTot; clr0 = clrTot; dn0 = doneTot;
      pulseStart();
      chk("busy_after_start", 32'(busy), 1);
      if (spurious) begin
         repeat (5) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      for (int w = 0; w < 16; w++) begin
         if (w == bpWin) out_ready = 1'b0;
         cyc = 0;
         while (!out_valid && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
         end
         chk("valid_wait", 32'(out_valid), 1);
         expD = tbl[sc].useRef ? refWin(w/4, w%4, 32'(tbl[sc].biasVal)) : tbl[sc].expData;
         chk("out_data", 32'(out_data), expD);
         chk("out_row", 32'(out_row), 32'(w/4));
         chk("out_col", 32'(out_col), 32'(w%4));
         if (w == bpWin) begin
            held = out_data;
            holdBad = 1'b0;
            repeat (10) begin
               @(posedge clk); #1;
               if (!out_valid || out_data !== held || img_rd) holdBad = 1'b1;
            end
            chk("bp_hold", 32'(holdBad), 0);
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk("bp_clear", 32'(dp_clear), 1);
         end else begin
            @(posedge clk); #1;
         end
      end
      chk("done_pulse", 32'(done), 1);
      chk("busy_in_finish", 32'(busy), 0);
      @(posedge clk); #1;
      chk("done_low", 32'(done), 0);
      repeat (3) @(posedge clk);
      #1 chk("idle_after_map", 32'(busy), 0);
      chk("rd_total", 32'(rdTot - rd0), 3456);
      chk("en_total", 32'(enTot - en0), 3456);
      chk("clr_total", 32'(clrTot - clr0), 96);
      chk("done_total", 32'(doneTot - dn0), 1);
      chk("addr_seq", 32'(addrErrs), 0);
      chk("en_timing", 32'(enErrs), 0);
   endtask

   initial begin
      int cyc;
      tbl[0] = '{8'd1,   8'd1,   16'd0,     216,      1'b0};
      tbl[1] = '{8'd255, 8'd255, 16'd65535, 14110935, 1'b0};
      tbl[2] = '{8'd2,   8'd3,   16'd100,   1396,     1'b0};
      tbl[3] = '{8'd0,   8'd77,  16'd5,     5,        1'b0};
      tbl[4] = '{8'd0,   8'd0,   16'd1234,  0,        1'b1};

      rst = 1'b0; start = 1'b0; bias = '0; out_ready = 1'b1;
      #3 rstChecks();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1 chk("idle_dp_clear", 32'(dp_clear), 0);

      runMap(0, -1, 1'b0);
      chk("spot_img_addr", 32'(spotImg), 183);
      chk("spot_pat_addr", 32'(spotPat), 79);
      runMap(1, -1, 1'b0);
      runMap(2, 3, 1'b1);
      runMap(3, -1, 1'b0);

      // Reset during STREAM of window 5, then a clean restart
      loadMem(4);
      pulseStart();
      cyc = 0;
      while (!(winIdx == 5 && img_rd) && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("reach_win5_stream", 32'(img_rd), 1);
      rst = 1'b0;
      #1 rstChecks();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      runMap(4, -1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
